// File: rtl/wave_seq_fetch.sv
// ---------------------------------------------------------------------------
// wave_seq_fetch
//
// Instruction sequencer for the waveform generator. Fetches 128-bit
// instructions from instruction memory, forwards SEGMENT instructions to the
// descriptor generator, runs JUMP instructions against a bank of loop counters
// and halts on END, on an illegal instruction, or on a stop request.
//
// Optional build macro: WAVE_SEQ_STATS_EN adds seg_count and cur_pc outputs.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, start_addr    begin execution at start_addr (only while idle)
//   stop                 graceful halt request, honoured at the next decode
//   rd_addr, rd_valid    instruction read request (held until rd_ack)
//   rd_ack, rd_data      read completion and instruction word
//   seg_data, seg_valid  SEGMENT instruction towards the generator
//   seg_ready            generator accepts seg_data
//   busy                 high from accepted start until back in IDLE
//   done                 one-cycle pulse on END or on stop completion
//   err, err_addr        sticky illegal-instruction flag and its address
//   seg_count, cur_pc    (WAVE_SEQ_STATS_EN only) segment count, current pc
// ---------------------------------------------------------------------------
module wave_seq_fetch #(
    parameter int ADDR_W    = 33,
    parameter int LOOP_NUM  = 8,
    parameter int CNT_W     = 16,
    parameter int ADDR_STEP = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ack,
    input  logic [127:0]      rd_data,
    output logic [127:0]      seg_data,
    output logic              seg_valid,
    input  logic              seg_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
`ifdef WAVE_SEQ_STATS_EN
    ,
    output logic [31:0]       seg_count,
    output logic [ADDR_W-1:0] cur_pc
`endif
);

    localparam logic [2:0] OP_SEGMENT = 3'b101;
    localparam logic [2:0] OP_JUMP    = 3'b111;
    localparam logic [2:0] OP_END     = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_JUMP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [127:0]      instr;
    logic [CNT_W-1:0]  cnt [LOOP_NUM];
    logic              stop_pend;

    // Decoded fields of the latched instruction word.
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] jump_target;
    logic [3:0]        jump_k;
    logic [CNT_W-1:0]  jump_t;
    logic              k_valid;
    logic [CNT_W-1:0]  sel_cnt;
    logic              jump_taken;
    logic [ADDR_W-1:0] pc_next;

    assign opcode      = instr[127:125];
    assign jump_target = instr[64+ADDR_W-1:64];
    assign jump_k      = instr[35:32];
    assign jump_t      = instr[CNT_W-1:0];
    assign k_valid     = ({28'd0, jump_k} < 32'(LOOP_NUM));
    assign pc_next     = pc + ADDR_W'(ADDR_STEP);

    // The latched word is held unchanged throughout ISSUE, so it doubles as
    // the segment payload without a second 128-bit register.
    assign seg_data = instr;

    // Counter selected by the current JUMP; the compare loop avoids indexing
    // the bank with a 4-bit field that may be wider than the bank needs.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < LOOP_NUM; i++) begin
            if (jump_k == 4'(i)) begin
                sel_cnt = cnt[i];
            end
        end
    end

    assign jump_taken = (sel_cnt < jump_t);

`ifdef WAVE_SEQ_STATS_EN
    assign cur_pc = pc;
`endif

    // Main sequencer. Every output apart from seg_data is a register updated
    // on the same edge as the state change it belongs to, so busy and done
    // line up exactly with the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr     <= '0;
            stop_pend <= 1'b0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            seg_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_addr  <= '0;
            for (int i = 0; i < LOOP_NUM; i++) begin
                cnt[i] <= '0;
            end
`ifdef WAVE_SEQ_STATS_EN
            seg_count <= '0;
`endif
        end else begin
            done <= 1'b0;

            // Stop is remembered while running; transitions to IDLE below
            // clear it again because their assignment comes later.
            if (busy && stop) begin
                stop_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        pc        <= start_addr;
                        rd_addr   <= start_addr;
                        rd_valid  <= 1'b1;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        stop_pend <= 1'b0;
                        for (int i = 0; i < LOOP_NUM; i++) begin
                            cnt[i] <= '0;
                        end
`ifdef WAVE_SEQ_STATS_EN
                        seg_count <= '0;
`endif
                        state     <= S_FETCH;
                    end
                end

                // A read is never abandoned: stop waits for the acknowledge.
                S_FETCH: begin
                    if (rd_ack) begin
                        instr    <= rd_data;
                        rd_valid <= 1'b0;
                        state    <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (stop_pend) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else if (opcode == OP_SEGMENT) begin
                        seg_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (opcode == OP_JUMP && k_valid) begin
                        state <= S_JUMP;
                    end else if (opcode == OP_END) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        err       <= 1'b1;
                        err_addr  <= pc;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                // seg_valid stays up until the generator takes the word,
                // even if stop arrives in the meantime.
                S_ISSUE: begin
                    if (seg_ready) begin
                        seg_valid <= 1'b0;
                        pc        <= pc_next;
                        rd_addr   <= pc_next;
                        rd_valid  <= 1'b1;
`ifdef WAVE_SEQ_STATS_EN
                        if (seg_count != 32'hFFFF_FFFF) begin
                            seg_count <= seg_count + 32'd1;
                        end
`endif
                        state     <= S_FETCH;
                    end
                end

                // Counter below T: count and branch back. Counter at T: rearm
                // it for the next time the loop is entered and fall through.
                S_JUMP: begin
                    for (int i = 0; i < LOOP_NUM; i++) begin
                        if (jump_k == 4'(i)) begin
                            cnt[i] <= jump_taken ? (cnt[i] + CNT_W'(1)) : '0;
                        end
                    end
                    if (jump_taken) begin
                        pc      <= jump_target;
                        rd_addr <= jump_target;
                    end else begin
                        pc      <= pc_next;
                        rd_addr <= pc_next;
                    end
                    rd_valid <= 1'b1;
                    state    <= S_FETCH;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_seq_fetch.sv
// ---------------------------------------------------------------------------
// tb_wave_seq_fetch
//
// Self-checking bench for wave_seq_fetch. A small instruction memory model
// answers reads with a configurable number of wait states, a segment sink
// accepts words with optional back-pressure, and expected results are
// hand-computed per program. Single-instruction decode cases are driven from
// a vector table; loops, stop, back-pressure and reset are hand sequences.
// ---------------------------------------------------------------------------
module tb_wave_seq_fetch;

    localparam int ADDR_W = 33;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_ack;
    logic [127:0]      rd_data;
    logic [127:0]      seg_data;
    logic              seg_valid;
    logic              seg_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
`ifdef WAVE_SEQ_STATS_EN
    logic [31:0]       seg_count;
    logic [ADDR_W-1:0] cur_pc;
`endif

    wave_seq_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .start_addr (start_addr),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .seg_data   (seg_data),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_addr   (err_addr)
`ifdef WAVE_SEQ_STATS_EN
        ,
        .seg_count  (seg_count),
        .cur_pc     (cur_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    logic [127:0]      mem [64];
    int                wait_states = 0;
    int                stall_left  = 0;
    int                done_n      = 0;
    logic [127:0]      seg_log [$];
    logic [ADDR_W-1:0] rd_log  [$];

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] mk_seg(input logic [63:0] tag);
        return {3'b101, 61'd0, tag};
    endfunction

    // Bits 120 and 20 lie outside the target and T fields and must be ignored.
    function automatic logic [127:0] mk_jump(input logic [ADDR_W-1:0] target,
                                             input logic [3:0] k, input logic [15:0] t);
        logic [127:0] w;
        w = '0;
        w[127:125]  = 3'b111;
        w[120]      = 1'b1;
        w[96:64]    = target;
        w[35:32]    = k;
        w[20]       = 1'b1;
        w[15:0]     = t;
        return w;
    endfunction

    function automatic logic [127:0] mk_end();
        return {3'b001, 125'd0};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic put(input logic [ADDR_W-1:0] addr, input logic [127:0] word);
        mem[addr[9:4]] = word;
    endtask

    // Instruction memory: holds rd_ack low for wait_states cycles, then acks
    // once. rd_addr must not move while a read is waiting.
    logic [ADDR_W-1:0] hold_addr;
    int                wait_cnt = 0;
    always @(negedge clk) begin
        if (rd_valid) begin
            if (wait_cnt == 0) hold_addr = rd_addr;
            else check_output("rd_addr_stable", rd_addr, hold_addr);
            if (wait_cnt < wait_states) begin
                rd_ack = 1'b0;
                wait_cnt++;
            end else begin
                rd_ack  = 1'b1;
                rd_data = mem[rd_addr[9:4]];
                rd_log.push_back(rd_addr);
                wait_cnt = 0;
            end
        end else begin
            rd_ack   = 1'b0;
            wait_cnt = 0;
        end
    end

    // Segment sink: stalls for stall_left valid cycles, then accepts.
    logic [127:0] seg_hold;
    logic         seg_seen = 1'b0;
    always @(negedge clk) begin
        if (seg_valid) begin
            if (seg_seen) check_output("seg_data_stable", seg_data, seg_hold);
            seg_hold = seg_data;
            seg_seen = 1'b1;
            if (stall_left > 0) begin
                seg_ready = 1'b0;
                stall_left--;
            end else begin
                seg_ready = 1'b1;
                seg_log.push_back(seg_data);
            end
        end else begin
            seg_ready = 1'b0;
            seg_seen  = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (done) done_n++;
    end

    // Pulses start and checks the one-cycle latency to the first read.
    task automatic apply_stimulus(input logic [ADDR_W-1:0] addr);
        @(negedge clk);
        seg_log.delete();
        rd_log.delete();
        done_n     = 0;
        start_addr = addr;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("start_rd_valid", rd_valid, 1'b1);
        check_output("start_rd_addr", rd_addr, addr);
        check_output("start_busy", busy, 1'b1);
        check_output("start_err_clear", err, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_reached", busy, 1'b0);
        if (busy) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_linear(input logic [ADDR_W-1:0] base);
        clear_mem();
        put(base,         mk_seg(64'hA000_0000_0000_00A1));
        put(base + 33'h10, mk_seg(64'hB000_0000_0000_00B2));
        put(base + 33'h20, mk_end());
    endtask

    task automatic check_linear(input string tag, input logic [ADDR_W-1:0] base);
        check_output({tag, "_seg_n"}, seg_log.size(), 2);
        if (seg_log.size() == 2) begin
            check_output({tag, "_seg0"}, seg_log[0], mk_seg(64'hA000_0000_0000_00A1));
            check_output({tag, "_seg1"}, seg_log[1], mk_seg(64'hB000_0000_0000_00B2));
        end
        check_output({tag, "_rd_n"}, rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check_output({tag, "_rd0"}, rd_log[0], base);
            check_output({tag, "_rd1"}, rd_log[1], base + 33'h10);
            check_output({tag, "_rd2"}, rd_log[2], base + 33'h20);
        end
        check_output({tag, "_done"}, done_n, 1);
        check_output({tag, "_err"}, err, 1'b0);
    endtask

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] addr;
        logic [127:0]      word;
        logic              exp_err;
        int                exp_done;
        int                exp_segs;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int o_n;
        int i_n;

        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        start_addr = '0;
        rd_ack     = 1'b0;
        rd_data    = '0;
        seg_ready  = 1'b0;
        clear_mem();

        vecs[0] = '{"seg_then_end", 33'h040, mk_seg(64'h5E6), 1'b0, 1, 1};
        vecs[1] = '{"op000",        33'h050, {3'b000, 125'd5}, 1'b1, 0, 0};
        vecs[2] = '{"op010",        33'h060, {3'b010, 125'd5}, 1'b1, 0, 0};
        vecs[3] = '{"op011",        33'h070, {3'b011, 125'd5}, 1'b1, 0, 0};
        vecs[4] = '{"op100",        33'h080, {3'b100, 125'd5}, 1'b1, 0, 0};
        vecs[5] = '{"op110",        33'h090, {3'b110, 125'd5}, 1'b1, 0, 0};
        vecs[6] = '{"end_only",     33'h0A0, mk_end(), 1'b0, 1, 0};
        vecs[7] = '{"jump_k9",      33'h0B0, mk_jump(33'h0, 4'd9, 16'd1), 1'b1, 0, 0};
        vecs[8] = '{"jump_k8",      33'h0C0, mk_jump(33'h0, 4'd8, 16'd0), 1'b1, 0, 0};
        vecs[9] = '{"jump_k7_t0",   33'h0D0, mk_jump(33'h0, 4'd7, 16'd0), 1'b0, 1, 0};

        #12;
        check_output("rst_rd_valid", rd_valid, 1'b0);
        check_output("rst_rd_addr", rd_addr, '0);
        check_output("rst_seg_valid", seg_valid, 1'b0);
        check_output("rst_seg_data", seg_data, '0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_done", done, 1'b0);
        check_output("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] linear run");
        load_linear(33'h100);
        apply_stimulus(33'h100);
        wait_idle();
        check_linear("linear", 33'h100);
`ifdef WAVE_SEQ_STATS_EN
        check_output("linear_seg_count", seg_count, 32'd2);
        check_output("linear_cur_pc", cur_pc, 33'h120);
`endif

        $display("[TB] decode vector table");
        for (int v = 0; v < 10; v++) begin
            clear_mem();
            put(vecs[v].addr, vecs[v].word);
            put(vecs[v].addr + 33'h10, mk_end());
            apply_stimulus(vecs[v].addr);
            wait_idle();
            check_output({vecs[v].name, "_err"}, err, vecs[v].exp_err);
            if (vecs[v].exp_err) check_output({vecs[v].name, "_err_addr"}, err_addr, vecs[v].addr);
            check_output({vecs[v].name, "_done"}, done_n, vecs[v].exp_done);
            check_output({vecs[v].name, "_segs"}, seg_log.size(), vecs[v].exp_segs);
        end

        $display("[TB] single loop");
        clear_mem();
        put(33'h00, mk_seg(64'hC0));
        put(33'h10, mk_jump(33'h0, 4'd0, 16'd3));
        put(33'h20, mk_end());
        apply_stimulus(33'h0);
        wait_idle();
        check_output("loop_segs", seg_log.size(), 4);
        check_output("loop_rd_n", rd_log.size(), 9);
        check_output("loop_cnt0", dut.cnt[0], 16'd0);
        check_output("loop_done", done_n, 1);
        check_output("loop_err", err, 1'b0);

        $display("[TB] nested loops");
        clear_mem();
        put(33'h00, mk_seg(64'h0_0001));
        put(33'h10, mk_seg(64'h1_0002));
        put(33'h20, mk_jump(33'h10, 4'd1, 16'd1));
        put(33'h30, mk_jump(33'h00, 4'd7, 16'd2));
        put(33'h40, mk_jump(33'h100, 4'd2, 16'd0));
        put(33'h50, mk_end());
        apply_stimulus(33'h0);
        wait_idle();
        o_n = 0;
        i_n = 0;
        foreach (seg_log[j]) begin
            if (seg_log[j] == mk_seg(64'h0_0001)) o_n++;
            if (seg_log[j] == mk_seg(64'h1_0002)) i_n++;
        end
        check_output("nested_outer", o_n, 3);
        check_output("nested_inner", i_n, 6);
        check_output("nested_rd_n", rd_log.size(), 20);
        if (rd_log.size() >= 2) begin
            check_output("nested_rd_t0", rd_log[rd_log.size()-2], 33'h40);
            check_output("nested_rd_end", rd_log[rd_log.size()-1], 33'h50);
        end
        check_output("nested_done", done_n, 1);
        check_output("nested_err", err, 1'b0);

        $display("[TB] back-pressure with stop");
        clear_mem();
        put(33'h200, mk_seg(64'hF1));
        put(33'h210, mk_seg(64'hF2));
        put(33'h220, mk_end());
        stall_left = 10;
        apply_stimulus(33'h200);
        for (int n = 0; n < 20 && !seg_valid; n++) @(negedge clk);
        check_output("bp_seg_valid", seg_valid, 1'b1);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle();
        check_output("bp_segs", seg_log.size(), 1);
        if (seg_log.size() == 1) check_output("bp_seg0", seg_log[0], mk_seg(64'hF1));
        check_output("bp_rd_n", rd_log.size(), 2);
        if (rd_log.size() == 2) check_output("bp_rd1", rd_log[1], 33'h210);
        check_output("bp_done", done_n, 1);
        check_output("bp_rd_valid", rd_valid, 1'b0);

        $display("[TB] illegal opcode then restart");
        clear_mem();
        put(33'h00, mk_seg(64'h11));
        put(33'h10, mk_seg(64'h12));
        put(33'h20, mk_seg(64'h13));
        put(33'h30, {3'b000, 125'd0});
        apply_stimulus(33'h0);
        wait_idle();
        check_output("ill_err", err, 1'b1);
        check_output("ill_err_addr", err_addr, 33'h30);
        check_output("ill_done", done_n, 0);
        check_output("ill_segs", seg_log.size(), 3);
        load_linear(33'h100);
        apply_stimulus(33'h100);
        wait_idle();
        check_linear("restart", 33'h100);

        $display("[TB] wait states");
        wait_states = 5;
        load_linear(33'h180);
        apply_stimulus(33'h180);
        wait_idle();
        check_linear("wait", 33'h180);

        $display("[TB] reset during fetch");
        apply_stimulus(33'h180);
        repeat (2) @(negedge clk);
        check_output("mid_rd_valid_before", rd_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_rd_valid", rd_valid, 1'b0);
        check_output("mid_rst_rd_addr", rd_addr, '0);
        check_output("mid_rst_busy", busy, 1'b0);
        check_output("mid_rst_seg_valid", seg_valid, 1'b0);
        check_output("mid_rst_err_addr", err_addr, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_states = 0;
        repeat (2) @(negedge clk);
        check_output("post_rst_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
